// File: rtl/alu_cmd_issuer.sv
// Command FIFO feeding a fixed-latency external ALU: issues one buffered command at a time,
// captures the result after ALU_LAT cycles and holds it until the consumer accepts it.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  output logic [2:0]               alu_opcode,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  input  logic [7:0]               alu_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_c,
  output logic [2:0]               out_opcode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);
  localparam bit SingleCycle = (ALU_LAT <= 1);
  // ISSUE already accounts for one cycle, so WAIT counts down from ALU_LAT-2 to 0.
  localparam logic [2:0] WaitLoad = (ALU_LAT > 1) ? 3'(ALU_LAT - 2) : 3'd0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResult
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      wait_q, wait_d;
  logic [10:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      alu_opcode_q;
  logic [3:0]      alu_a_q, alu_b_q;
  logic [7:0]      out_c_q;
  logic [2:0]      out_opcode_q;
  logic            push, pop, capture;
  logic            not_empty;

  assign not_empty  = (count_q != '0);
  assign in_ready   = (count_q != Full);
  assign push       = in_valid && in_ready;
  assign count      = count_q;
  assign out_valid  = (state_q == StResult);
  assign out_c      = out_c_q;
  assign out_opcode = out_opcode_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

  // FIFO storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= {in_opcode, in_a, in_b};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Popping happens on the edge that enters ISSUE, so the head lands on alu_* in that state.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (not_empty) begin
          state_d = StIssue;
          pop     = 1'b1;
        end
      end
      StIssue: begin
        if (SingleCycle) begin
          state_d = StResult;
          capture = 1'b1;
        end else begin
          state_d = StWait;
          wait_d  = WaitLoad;
        end
      end
      StWait: begin
        if (wait_q == 3'd0) begin
          state_d = StResult;
          capture = 1'b1;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      StResult: begin
        if (out_ready) begin
          if (not_empty) begin
            state_d = StIssue;
            pop     = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      wait_q       <= 3'd0;
      alu_opcode_q <= 3'b000;
      alu_a_q      <= 4'h0;
      alu_b_q      <= 4'h0;
      out_c_q      <= 8'h00;
      out_opcode_q <= 3'b000;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (pop) begin
        {alu_opcode_q, alu_a_q, alu_b_q} <= mem_q[rd_ptr_q];
      end
      if (capture) begin
        out_c_q      <= alu_c;
        out_opcode_q <= alu_opcode_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: one DUT at ALU_LAT=1 with a modelled ALU, one at
// ALU_LAT=3 whose alu_c is driven cycle by cycle.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_opcode;
  logic [3:0] in_a, in_b;
  logic       out_ready;
  logic [7:0] alu_c3;

  logic       d1_in_ready, d1_out_valid;
  logic [2:0] d1_alu_opcode, d1_out_opcode, d1_count;
  logic [3:0] d1_alu_a, d1_alu_b;
  logic [7:0] d1_alu_c, d1_out_c;

  logic       d3_in_ready, d3_out_valid;
  logic [2:0] d3_alu_opcode, d3_out_opcode, d3_count;
  logic [3:0] d3_alu_a, d3_alu_b;
  logic [7:0] d3_out_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    case (op)
      3'b000:  return {4'h0, a} + {4'h0, b};
      3'b001:  return {4'h0, a} - {4'h0, b};
      3'b010:  return {4'h0, a & b};
      3'b011:  return {4'h0, a | b};
      3'b100:  return {4'h0, a ^ b};
      3'b101:  return {4'h0, a} * {4'h0, b};
      default: return 8'h00;
    endcase
  endfunction

  assign d1_alu_c = alu_model(d1_alu_opcode, d1_alu_a, d1_alu_b);

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d1_in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .alu_opcode(d1_alu_opcode),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_c(d1_alu_c), .out_valid(d1_out_valid),
    .out_ready(out_ready), .out_c(d1_out_c), .out_opcode(d1_out_opcode), .count(d1_count)
  );

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d3_in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .alu_opcode(d3_alu_opcode),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_c(alu_c3), .out_valid(d3_out_valid),
    .out_ready(out_ready), .out_c(d3_out_c), .out_opcode(d3_out_opcode), .count(d3_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = 3'b000;
    in_a      = 4'h0;
    in_b      = 4'h0;
    out_ready = 1'b0;
    alu_c3    = 8'h00;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (d1_count !== 3'd0 || d1_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_count_ready got count=%0d ready=%b exp count=0 ready=1",
               d1_count, d1_in_ready);
    end
    checks++;
    if ({d1_out_valid, d1_out_c, d1_out_opcode, d1_alu_opcode, d1_alu_a, d1_alu_b} !== 23'd0)
    begin
      failures++;
      $display("FAIL reset_outputs_d1 got valid=%b c=%h op=%b alu=%b/%h/%h exp all zero",
               d1_out_valid, d1_out_c, d1_out_opcode, d1_alu_opcode, d1_alu_a, d1_alu_b);
    end
    checks++;
    if ({d3_out_valid, d3_out_c, d3_out_opcode, d3_alu_opcode, d3_alu_a, d3_alu_b,
         d3_count} !== 26'd0 || d3_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs_d3 got valid=%b c=%h count=%0d ready=%b exp zero/ready=1",
               d3_out_valid, d3_out_c, d3_count, d3_in_ready);
    end
  endtask

  task automatic test_single_add();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_opcode = 3'b000;
    in_a      = 4'h3;
    in_b      = 4'h5;
    step();
    in_valid = 1'b0;
    checks++;
    if (d1_count !== 3'd1 || {d1_alu_opcode, d1_alu_a, d1_alu_b} !== 11'd0) begin
      failures++;
      $display("FAIL add_no_bypass got count=%0d alu=%b/%h/%h exp count=1 alu=0/0/0",
               d1_count, d1_alu_opcode, d1_alu_a, d1_alu_b);
    end
    step();
    checks++;
    if ({d1_alu_opcode, d1_alu_a, d1_alu_b} !== {3'b000, 4'h3, 4'h5} || d1_out_valid !== 1'b0)
    begin
      failures++;
      $display("FAIL add_issue got alu=%b/%h/%h valid=%b exp alu=000/3/5 valid=0",
               d1_alu_opcode, d1_alu_a, d1_alu_b, d1_out_valid);
    end
    step();
    checks++;
    if (d1_out_valid !== 1'b1 || d1_out_c !== 8'h08 || d1_out_opcode !== 3'b000) begin
      failures++;
      $display("FAIL add_result got valid=%b c=%h op=%b exp valid=1 c=08 op=000",
               d1_out_valid, d1_out_c, d1_out_opcode);
    end
    step();
    checks++;
    if (d1_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_consumed got valid=%b exp 0", d1_out_valid);
    end
  endtask

  task automatic test_fill_backpressure();
    logic [2:0] ops [5];
    logic [3:0] as  [5];
    logic [3:0] bs  [5];
    logic [7:0] exp_c [5];
    int n;
    ops = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    as  = '{4'h9, 4'hC, 4'h1, 4'hF, 4'h7};
    bs  = '{4'h4, 4'hA, 4'h2, 4'h5, 4'h3};
    exp_c = '{8'h05, 8'h08, 8'h03, 8'h0A, 8'h15};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_opcode = ops[i];
      in_a      = as[i];
      in_b      = bs[i];
      checks++;
      if (d1_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL fill_ready_%0d got %b exp 1", i, d1_in_ready);
      end
      step();
    end
    checks++;
    if (d1_count !== 3'd4 || d1_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full got count=%0d ready=%b exp count=4 ready=0",
               d1_count, d1_in_ready);
    end
    in_opcode = 3'b110;
    in_a      = 4'hE;
    in_b      = 4'hE;
    // Offer stays up while the result is held; nothing may move.
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (d1_out_valid !== 1'b1 || d1_out_c !== 8'h05 || d1_out_opcode !== 3'b001 ||
          d1_alu_a !== 4'h9 || d1_count !== 3'd4 || d1_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle_%0d got valid=%b c=%h op=%b alu_a=%h count=%0d exp 1/05/001/9/4",
                 i, d1_out_valid, d1_out_c, d1_out_opcode, d1_alu_a, d1_count);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (d1_out_valid !== 1'b1 && n < 10) begin
        step();
        n++;
      end
      checks++;
      if (d1_out_valid !== 1'b1 || d1_out_c !== exp_c[i] || d1_out_opcode !== ops[i]) begin
        failures++;
        $display("FAIL drain_%0d got valid=%b c=%h op=%b exp valid=1 c=%h op=%b",
                 i, d1_out_valid, d1_out_c, d1_out_opcode, exp_c[i], ops[i]);
      end
      if (i > 0) begin
        checks++;
        if (n != 1) begin
          failures++;
          $display("FAIL drain_gap_%0d got %0d idle cycles exp 1", i, n);
        end
      end
      step();
    end
    checks++;
    if (d1_count !== 3'd0 || d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_end got count=%0d valid=%b ready=%b exp 0/0/1",
               d1_count, d1_out_valid, d1_in_ready);
    end
  endtask

  task automatic test_back_to_back_wrap();
    int nxt;
    int got;
    int cyc;
    logic pushed;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_opcode = 3'b000;
      in_a      = 4'(i + 1);
      in_b      = 4'(i);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (d1_count !== 3'd2 || d1_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_prefill got count=%0d valid=%b exp count=2 valid=1",
               d1_count, d1_out_valid);
    end
    nxt = 3;
    got = 0;
    cyc = 0;
    while (got < 9 && cyc < 60) begin
      pushed = 1'b0;
      if (d1_out_valid === 1'b1) begin
        checks++;
        if (d1_out_c !== 8'(2 * got + 1)) begin
          failures++;
          $display("FAIL wrap_result_%0d got %h exp %h", got, d1_out_c, 8'(2 * got + 1));
        end
        got++;
        out_ready = 1'b1;
        if (nxt < 9) begin
          in_valid  = 1'b1;
          in_opcode = 3'b000;
          in_a      = 4'(nxt + 1);
          in_b      = 4'(nxt);
          nxt++;
          pushed = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
      step();
      cyc++;
      if (pushed) begin
        checks++;
        if (d1_count !== 3'd2) begin
          failures++;
          $display("FAIL wrap_count_push%0d got %0d exp 2", nxt - 1, d1_count);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 9) begin
      failures++;
      $display("FAIL wrap_timeout got %0d results exp 9", got);
    end
    step();
    checks++;
    if (d1_count !== 3'd0 || d1_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_end got count=%0d valid=%b exp 0/0", d1_count, d1_out_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    do_reset();
    in_valid = 1'b1;
    in_opcode = 3'b001; in_a = 4'h9; in_b = 4'h4; step();
    in_opcode = 3'b010; in_a = 4'hC; in_b = 4'hA; step();
    in_opcode = 3'b011; in_a = 4'h1; in_b = 4'h2; step();
    in_valid = 1'b0;
    checks++;
    if (d3_alu_a !== 4'h9 || d3_count !== 3'd2 || d3_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midwait_pre got alu_a=%h count=%0d valid=%b exp 9/2/0",
               d3_alu_a, d3_count, d3_out_valid);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({d3_out_valid, d3_out_c, d3_out_opcode, d3_alu_opcode, d3_alu_a, d3_alu_b,
         d3_count} !== 26'd0 || d3_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midwait_reset got valid=%b c=%h alu=%b/%h/%h count=%0d exp all zero",
               d3_out_valid, d3_out_c, d3_alu_opcode, d3_alu_a, d3_alu_b, d3_count);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (d3_out_valid !== 1'b0 || d3_count !== 3'd0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midwait_quiet got %0d active cycles exp 0", seen);
    end
  endtask

  task automatic test_latency3();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_opcode = 3'b000;
    in_a      = 4'h2;
    in_b      = 4'h3;
    alu_c3    = 8'h00;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if ({d3_alu_opcode, d3_alu_a, d3_alu_b} !== {3'b000, 4'h2, 4'h3}) begin
      failures++;
      $display("FAIL lat3_issue got alu=%b/%h/%h exp 000/2/3",
               d3_alu_opcode, d3_alu_a, d3_alu_b);
    end
    alu_c3 = 8'h11;
    step();
    alu_c3 = 8'h22;
    checks++;
    if (d3_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat3_early1 got valid=%b exp 0", d3_out_valid);
    end
    step();
    alu_c3 = 8'h33;
    checks++;
    if (d3_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat3_early2 got valid=%b exp 0", d3_out_valid);
    end
    step();
    alu_c3 = 8'h44;
    checks++;
    if (d3_out_valid !== 1'b1 || d3_out_c !== 8'h33 || d3_out_opcode !== 3'b000) begin
      failures++;
      $display("FAIL lat3_capture got valid=%b c=%h op=%b exp 1/33/000",
               d3_out_valid, d3_out_c, d3_out_opcode);
    end
    step();
    checks++;
    if (d3_out_valid !== 1'b1 || d3_out_c !== 8'h33) begin
      failures++;
      $display("FAIL lat3_hold got valid=%b c=%h exp 1/33", d3_out_valid, d3_out_c);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fill_backpressure();
    test_back_to_back_wrap();
    test_reset_mid_wait();
    test_latency3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter: ALU_LAT, default 1, cycles from ALU operand drive to alu_c sample (1..7).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream command valid.
REQ-006 in_ready  output  1  command accepted when in_valid && in_ready at posedge.
REQ-007 in_opcode  input  3  ALU opcode of offered command.
REQ-008 in_a, in_b  input  4 each  operands of offered command.
REQ-009 alu_opcode  output  3  opcode driven to the ALU.
REQ-010 alu_a, alu_b  output  4 each  operands driven to the ALU.
REQ-011 alu_c  input  8  ALU result.
REQ-012 out_valid  output  1  result valid to the downstream consumer.
REQ-013 out_ready  input  1  downstream accepts the result when out_valid && out_ready at posedge.
REQ-014 out_c  output  8  captured ALU result.
REQ-015 out_opcode  output  3  opcode that produced out_c.
REQ-016 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 The block SHALL buffer accepted commands {opcode,a,b} in a DEPTH-entry circular FIFO with wrap-around read/write pointers.
REQ-018 in_ready SHALL equal (count != DEPTH), combinational from registered count only; no dependence on in_valid or pop in the same cycle.
REQ-019 A push when full SHALL be impossible (in_ready low); offered data SHALL be ignored and FIFO contents unchanged.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, RESULT; exactly one command outstanding at a time.
REQ-022 IDLE -> ISSUE when count != 0; stay in IDLE otherwise; no bypass of an empty FIFO (a command accepted at edge N is issued no earlier than edge N+1).
REQ-023 On entry to ISSUE the FIFO head SHALL be popped and registered onto alu_opcode/alu_a/alu_b; these outputs SHALL hold that value until the next ISSUE.
REQ-024 ISSUE -> WAIT unconditionally; WAIT SHALL last ALU_LAT-1 cycles using a down-counter (zero cycles when ALU_LAT=1, i.e. ISSUE -> capture directly).
REQ-025 alu_c SHALL be sampled into out_c exactly ALU_LAT cycles after alu_* were driven; out_opcode SHALL be loaded with the issued opcode at the same edge; state -> RESULT, out_valid=1.
REQ-026 In RESULT, out_valid, out_c, out_opcode SHALL remain stable until out_ready is sampled high.
REQ-027 RESULT with out_ready=1 -> ISSUE if count != 0 (back-to-back), else IDLE; out_valid deasserts at that edge.
REQ-028 RESULT with out_ready=0 SHALL stall issue; FIFO continues to accept pushes until full.
REQ-029 Throughput with out_ready tied high and ALU_LAT=1: one result every 2 cycles.
REQ-030 All arithmetic on pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-031 When reset=0 at a posedge: state=IDLE, pointers=0, count=0, out_valid=0, out_c=8'h00, out_opcode=3'b000, alu_opcode=3'b000, alu_a=4'h0, alu_b=4'h0, WAIT counter=0.
REQ-032 Reset asserted mid-operation (any state) SHALL discard the outstanding command and all FIFO contents; no result for them SHALL appear after reset release.
REQ-033 in_ready SHALL be 1 on the first cycle after reset release (count=0).

Verification
REQ-034 Single add: push {000,4'h3,4'h5}, out_ready=1, ALU_LAT=1 -> alu_*={000,3,5} one cycle after push; out_valid=1 with out_c=8'h08, out_opcode=000 two cycles later.
REQ-035 Fill: push 5 commands with out_ready=0, DEPTH=4 -> first issues, 4 more buffered, in_ready=0 at count=4, 6th offer ignored; then out_ready=1 -> results emerge in push order.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles with result pending -> out_valid, out_c, out_opcode stable throughout, no new ISSUE.
REQ-037 Push/pop same cycle at count=2 -> count stays 2, order preserved across pointer wrap (run 9 commands through DEPTH=4).
REQ-038 Reset mid-WAIT with ALU_LAT=3 and 2 commands buffered -> all outputs at REQ-031 values next cycle, no out_valid until a new command is pushed.
REQ-039 ALU_LAT=3: alu_c sampled exactly 3 cycles after alu_* change; a changed alu_c value at cycle 2 or 4 SHALL NOT appear on out_c.
